// File: rtl/conv_pkg.sv
// Shared conv-layer constants, data word type and the saturate/ReLU stage
// reused by the conv, pooling and dense blocks.
package conv_pkg;

  localparam int unsigned CONV_DATA_W = 16;
  localparam int unsigned CONV_FRAC_W = 10;
  localparam int unsigned SAT_W       = 64;

  typedef logic signed [CONV_DATA_W-1:0] data_t;

  // Clamp a wide signed value into an out_w-bit signed range, then optionally ReLU
  function automatic logic signed [SAT_W-1:0] sat_relu(
    input logic signed [SAT_W-1:0] value,
    input logic                    relu_en,
    input int unsigned             out_w = CONV_DATA_W
  );
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    logic signed [SAT_W-1:0] r;
    hi = (SAT_W'(1) <<< (out_w - 1)) - SAT_W'(1);
    lo = -hi - SAT_W'(1);
    r  = value;
    if (value > hi) begin
      r = hi;
    end else if (value < lo) begin
      r = lo;
    end
    if (relu_en && r[SAT_W-1]) begin
      r = '0;
    end
    return r;
  endfunction

endpackage

// File: rtl/conv_column_dot.sv
// Combinational dot product of one K-tall input column with the matching
// weight column, full precision, sign-extended to the accumulator width.
module conv_column_dot #(
  parameter int unsigned K      = 3,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ACC_W  = 2*DATA_W + $clog2(K*K)
) (
  input  logic [K*DATA_W-1:0]     samples,
  input  logic [K*DATA_W-1:0]     wts,
  output logic signed [ACC_W-1:0] colsum
);

  localparam int unsigned PROD_W = 2*DATA_W;

  logic signed [PROD_W-1:0] prod [K];

  for (genvar r = 0; r < K; r++) begin : g_mul
    assign prod[r] = PROD_W'($signed(samples[r*DATA_W +: DATA_W]))
                   * PROD_W'($signed(wts[r*DATA_W +: DATA_W]));
  end

  always_comb begin
    colsum = '0;
    for (int r = 0; r < K; r++) begin
      colsum = colsum + ACC_W'(prod[r]);
    end
  end

endmodule

// File: rtl/conv_window_mac.sv
// KxK convolution window MAC for one filter: accumulates K column beats,
// then rescales, biases, saturates and optionally ReLUs one output pixel.
module conv_window_mac
  import conv_pkg::*;
#(
  parameter int unsigned K       = 3,
  parameter int unsigned DATA_W  = CONV_DATA_W,
  parameter int unsigned FRAC_W  = CONV_FRAC_W,
  parameter int unsigned ACC_W   = 2*DATA_W + $clog2(K*K),
  parameter int unsigned RELU_EN = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [K*DATA_W-1:0]   in_col,
  input  logic [K*K*DATA_W-1:0] weights,
  input  logic [DATA_W-1:0]     bias,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_data,
  output logic                  busy
);

  localparam int unsigned CNT_W = $clog2(K);

  logic [CNT_W-1:0]        col_cnt, cnt_d;
  logic signed [ACC_W-1:0] acc, acc_d, colsum, total, shifted;
  logic signed [SAT_W-1:0] biased;
  logic [DATA_W-1:0]       result, out_data_d;
  logic                    out_valid_d, accept, last;
  logic [DATA_W-1:0]       w_arr [K][K];
  logic [K*DATA_W-1:0]     wcol;

  // Pick the weight column matching the current beat
  for (genvar r = 0; r < K; r++) begin : g_wrow
    for (genvar c = 0; c < K; c++) begin : g_wcol
      assign w_arr[r][c] = weights[(r*K+c)*DATA_W +: DATA_W];
    end
    assign wcol[r*DATA_W +: DATA_W] = w_arr[r][col_cnt];
  end

  conv_column_dot #(
    .K      (K),
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_dot (
    .samples (in_col),
    .wts     (wcol),
    .colsum  (colsum)
  );

  assign in_ready = !(out_valid && !out_ready);
  assign busy     = (col_cnt != '0);
  assign accept   = in_valid && in_ready;
  assign last     = (col_cnt == CNT_W'(K - 1));
  assign total    = acc + colsum;
  assign shifted  = total >>> FRAC_W;
  assign biased   = SAT_W'(shifted) + SAT_W'($signed(bias));
  assign result   = DATA_W'(sat_relu(biased, RELU_EN != 0, DATA_W));

  // Next-state: clear beats any accept; a LAST accept outranks the output handshake
  always_comb begin
    acc_d       = acc;
    cnt_d       = col_cnt;
    out_valid_d = out_valid;
    out_data_d  = out_data;
    if (clear) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (accept) begin
      if (last) begin
        acc_d = '0;
        cnt_d = '0;
      end else begin
        acc_d = (col_cnt == '0) ? colsum : total;
        cnt_d = col_cnt + CNT_W'(1);
      end
    end
    if (!clear && accept && last) begin
      out_valid_d = 1'b1;
      out_data_d  = result;
    end else if (out_valid && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc       <= '0;
      col_cnt   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      acc       <= acc_d;
      col_cnt   <= cnt_d;
      out_valid <= out_valid_d;
      out_data  <= out_data_d;
    end
  end

  // The filter must not move under a partially accumulated window
  weights_stable_a : assert property (@(posedge clock) disable iff (!reset_n)
    busy |-> $stable(weights));

endmodule

// File: tb/tb_conv_window_mac.sv
// Directed bench for conv_window_mac: a ReLU and a linear instance share all
// stimulus; vector table plus hand-written stall, clear and reset sequences.
module tb_conv_window_mac;
  import conv_pkg::*;

  localparam int unsigned K  = 3;
  localparam int unsigned DW = CONV_DATA_W;
  localparam int unsigned NV = 10;

  logic                 clock = 1'b0;
  logic                 reset_n = 1'b0;
  logic                 clear = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 out_ready = 1'b1;
  logic [K*DW-1:0]      in_col = '0;
  logic [K*K*DW-1:0]    weights = '0;
  logic [DW-1:0]        bias = '0;
  logic                 in_ready_r, in_ready_l, out_valid_r, out_valid_l, busy_r, busy_l;
  logic signed [DW-1:0] out_data_r, out_data_l;

  int          n_checks = 0;
  int          n_fail = 0;
  int          accepted = 0;
  int          base = 0;
  bit          released = 1'b0;
  data_t       got [$];

  typedef struct {
    logic [K*DW-1:0]   col;
    logic [K*K*DW-1:0] w;
    data_t             b;
    data_t             exp_relu;
    data_t             exp_lin;
  } vec_t;
  vec_t vecs [NV];

  always #5 clock = ~clock;

  conv_window_mac #(.K(K), .DATA_W(DW), .FRAC_W(CONV_FRAC_W), .RELU_EN(1)) u_relu (
    .clock(clock), .reset_n(reset_n), .clear(clear), .in_valid(in_valid),
    .in_ready(in_ready_r), .in_col(in_col), .weights(weights), .bias(bias),
    .out_valid(out_valid_r), .out_ready(out_ready), .out_data(out_data_r), .busy(busy_r));

  conv_window_mac #(.K(K), .DATA_W(DW), .FRAC_W(CONV_FRAC_W), .RELU_EN(0)) u_lin (
    .clock(clock), .reset_n(reset_n), .clear(clear), .in_valid(in_valid),
    .in_ready(in_ready_l), .in_col(in_col), .weights(weights), .bias(bias),
    .out_valid(out_valid_l), .out_ready(out_ready), .out_data(out_data_l), .busy(busy_l));

  // Count data beats taken and collect delivered pixels
  always @(posedge clock) begin
    if (reset_n) begin
      if (in_valid && in_ready_r && !clear) accepted <= accepted + 1;
      if (out_valid_r && out_ready) got.push_back(out_data_r);
    end
  end

  function automatic logic [K*DW-1:0] fill_col(input data_t v);
    logic [K*DW-1:0] c;
    for (int r = 0; r < K; r++) c[r*DW +: DW] = v;
    return c;
  endfunction

  function automatic logic [K*DW-1:0] row0_col(input data_t v);
    logic [K*DW-1:0] c;
    c = '0;
    c[DW-1:0] = v;
    return c;
  endfunction

  function automatic logic [K*K*DW-1:0] fill_w(input data_t v);
    logic [K*K*DW-1:0] w;
    for (int i = 0; i < K*K; i++) w[i*DW +: DW] = v;
    return w;
  endfunction

  function automatic logic [K*K*DW-1:0] w00(input data_t v);
    logic [K*K*DW-1:0] w;
    w = '0;
    w[DW-1:0] = v;
    return w;
  endfunction

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Present one column until n beats are taken; called just after a negedge
  task automatic send_beats(input int n, input logic [K*DW-1:0] col);
    int b0;
    b0 = accepted;
    in_col = col;
    in_valid = 1'b1;
    for (int c = 0; c < 50 && accepted < b0 + n; c++) @(negedge clock);
    in_valid = 1'b0;
    check("beats_taken", accepted - b0, n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{fill_col(16'sd1024),  fill_w(16'sd1024),   16'sd0,     16'sd9216,  16'sd9216};
    vecs[1] = '{fill_col(16'sd1024),  fill_w(-16'sd1024),  16'sd0,     16'sd0,    -16'sd9216};
    vecs[2] = '{fill_col(16'sd16384), fill_w(16'sd16384),  16'sd0,     16'sd32767, 16'sd32767};
    vecs[3] = '{fill_col(16'sd16384), fill_w(-16'sd16384), 16'sd0,     16'sd0,     16'sh8000};
    vecs[4] = '{row0_col(16'sd1),     w00(16'sd1),         16'sd512,   16'sd512,   16'sd512};
    vecs[5] = '{row0_col(16'sd1),     w00(16'sd1024),      16'sd512,   16'sd513,   16'sd513};
    vecs[6] = '{row0_col(-16'sd1),    w00(16'sd1024),      16'sd0,     16'sd0,    -16'sd1};
    vecs[7] = '{row0_col(-16'sd1),    w00(16'sd1),         16'sd0,     16'sd0,    -16'sd1};
    vecs[8] = '{fill_col(16'sd1024),  fill_w(16'sd1024),  -16'sd1024,  16'sd8192,  16'sd8192};
    vecs[9] = '{fill_col(16'sd1024),  fill_w(-16'sd1024),  16'sd16384, 16'sd7168,  16'sd7168};

    #12;
    check("rst_out_valid", 32'(out_valid_r), 0);
    check("rst_out_data", out_data_r, 0);
    check("rst_busy", 32'(busy_r), 0);
    check("rst_in_ready", 32'(in_ready_r), 1);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    for (int i = 0; i < NV; i++) begin
      weights = vecs[i].w;
      bias    = vecs[i].b;
      send_beats(2, vecs[i].col);
      check("mid_out_valid", 32'(out_valid_r), 0);
      check("mid_busy", 32'(busy_r), 1);
      send_beats(1, vecs[i].col);
      check("vec_valid_relu", 32'(out_valid_r), 1);
      check("vec_valid_lin", 32'(out_valid_l), 1);
      check("vec_data_relu", out_data_r, vecs[i].exp_relu);
      check("vec_data_lin", out_data_l, vecs[i].exp_lin);
      check("vec_busy_done", 32'(busy_l), 0);
    end

    // Backpressure: second pixel stalls the producer, then both drain in order
    weights = fill_w(16'sd1024);
    bias = '0;
    @(negedge clock);
    got.delete();
    out_ready = 1'b0;
    base = accepted;
    in_col = fill_col(16'sd1024);
    in_valid = 1'b1;
    for (int c = 0; c < 60 && accepted < base + 6; c++) begin
      @(negedge clock);
      if (accepted == base + 3 && !released) begin
        check("stall_in_ready", 32'(in_ready_r), 0);
        check("stall_valid", 32'(out_valid_r), 1);
        check("stall_data", out_data_r, 9216);
        repeat (4) @(negedge clock);
        check("hold_valid", 32'(out_valid_r), 1);
        check("hold_data", out_data_r, 9216);
        check("hold_no_accept", accepted - base, 3);
        out_ready = 1'b1;
        released = 1'b1;
      end
    end
    in_valid = 1'b0;
    for (int c = 0; c < 20 && got.size() < 2; c++) @(negedge clock);
    check("stall_reached", 32'(released), 1);
    check("drain_count", got.size(), 2);
    check("drain_pix0", (got.size() > 0) ? got[0] : 16'sd0, 9216);
    check("drain_pix1", (got.size() > 1) ? got[1] : 16'sd0, 9216);

    // Clear: drop a partial window and a beat coinciding with clear
    send_beats(2, fill_col(16'sd16384));
    check("pre_clear_busy", 32'(busy_r), 1);
    clear = 1'b1;
    in_valid = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    in_valid = 1'b0;
    check("post_clear_busy", 32'(busy_r), 0);
    send_beats(3, fill_col(16'sd1024));
    check("clear_valid", 32'(out_valid_r), 1);
    check("clear_data_relu", out_data_r, 9216);
    check("clear_data_lin", out_data_l, 9216);
    out_ready = 1'b0;
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    check("clear_keeps_valid", 32'(out_valid_r), 1);
    check("clear_keeps_data", out_data_r, 9216);
    out_ready = 1'b1;
    @(negedge clock);
    check("handshake_drops_valid", 32'(out_valid_r), 0);

    // Asynchronous reset in the middle of a window
    send_beats(2, fill_col(16'sd1024));
    check("pre_rst_busy", 32'(busy_r), 1);
    #2 reset_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy_r), 0);
    check("arst_valid", 32'(out_valid_r), 0);
    check("arst_data", out_data_r, 0);
    check("arst_in_ready", 32'(in_ready_r), 1);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    send_beats(3, fill_col(16'sd1024));
    check("post_rst_valid", 32'(out_valid_r), 1);
    check("post_rst_data", out_data_r, 9216);
    check("post_rst_lin", out_data_l, 9216);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
